// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants, state encoding and key lookup helpers for the PS/2
// keycode source. Scan codes are PS/2 set 2; output codes are USB-HID usage IDs.
package ps2_pkg;

    // Frame receiver states (plain constants for compatibility with older tools)
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    // Prefix bytes
    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    // Tracked set-2 scan codes
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_SPACE = 8'h29;

    // Matching HID codes
    localparam logic [7:0] HID_NONE  = 8'h00;
    localparam logic [7:0] HID_A     = 8'h04;
    localparam logic [7:0] HID_D     = 8'h07;
    localparam logic [7:0] HID_S     = 8'h16;
    localparam logic [7:0] HID_W     = 8'h1A;
    localparam logic [7:0] HID_SPACE = 8'h2C;

    // Index doubles as the bit position in the held mask; lower index wins fallback
    typedef enum logic [2:0] {
        KeyA     = 3'd0,
        KeyD     = 3'd1,
        KeyS     = 3'd2,
        KeyW     = 3'd3,
        KeySpace = 3'd4,
        KeyNone  = 3'd7
    } key_idx_e;

    function automatic key_idx_e scan_to_idx(input logic [7:0] sc);
        case (sc)
            SC_A:     return KeyA;
            SC_D:     return KeyD;
            SC_S:     return KeyS;
            SC_W:     return KeyW;
            SC_SPACE: return KeySpace;
            default:  return KeyNone;
        endcase
    endfunction

    function automatic logic [7:0] idx_to_hid(input key_idx_e idx);
        case (idx)
            KeyA:     return HID_A;
            KeyD:     return HID_D;
            KeyS:     return HID_S;
            KeyW:     return HID_W;
            KeySpace: return HID_SPACE;
            default:  return HID_NONE;
        endcase
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: PS/2 device-to-host frame receiver.
//   Clk, Reset          system clock, async active-high reset
//   ps2_clk, ps2_data   raw PS/2 lines, asynchronous to Clk
//   byte_valid          one-cycle pulse per correctly framed byte
//   scan_byte           last correctly framed byte
//   frame_err           one-cycle pulse on start/parity/stop/timeout error
// FILTER_LEN must be at least 2.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] scan_byte,
    output logic       frame_err
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] TmoLast = CntW'(TIMEOUT_CYCLES - 1);

    logic                  clk_meta_q, clk_sync_q, data_meta_q, data_sync_q;
    logic [FILTER_LEN-1:0] hist_q, hist_d;
    logic                  filt_q, filt_d;
    logic                  fall;
    logic [1:0]            state_q, state_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [7:0]            shift_q, shift_d;
    logic                  parity_q, parity_d;
    logic [CntW-1:0]       tmo_q, tmo_d;
    logic                  byte_valid_q, byte_valid_d;
    logic [7:0]            scan_byte_q, scan_byte_d;
    logic                  frame_err_q, frame_err_d;

    always_comb begin
        hist_d = {hist_q[FILTER_LEN-2:0], clk_sync_q};
        // Level only moves once the whole history agrees
        filt_d = filt_q;
        if (&hist_q)       filt_d = 1'b1;
        else if (~|hist_q) filt_d = 1'b0;
        fall = filt_q & ~filt_d;

        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        tmo_d        = tmo_q;
        byte_valid_d = 1'b0;
        scan_byte_d  = scan_byte_q;
        frame_err_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    if (!data_sync_q) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 3'd0;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (fall) begin
                    shift_d   = {data_sync_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
                end
            end
            ST_PARITY: begin
                if (fall) begin
                    parity_d = data_sync_q;
                    state_d  = ST_STOP;
                end
            end
            default: begin
                if (fall) begin
                    if (data_sync_q && (^{shift_q, parity_q})) begin
                        byte_valid_d = 1'b1;
                        scan_byte_d  = shift_q;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
            end
        endcase

        // Inter-edge watchdog; idle line may stay high indefinitely
        if (state_q == ST_IDLE) begin
            tmo_d = '0;
        end else if (fall) begin
            tmo_d = '0;
        end else if (tmo_q == TmoLast) begin
            tmo_d       = '0;
            frame_err_d = 1'b1;
            state_d     = ST_IDLE;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            clk_meta_q   <= 1'b1;
            clk_sync_q   <= 1'b1;
            data_meta_q  <= 1'b1;
            data_sync_q  <= 1'b1;
            hist_q       <= '1;
            filt_q       <= 1'b1;
            state_q      <= ST_IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            parity_q     <= 1'b0;
            tmo_q        <= '0;
            byte_valid_q <= 1'b0;
            scan_byte_q  <= 8'h00;
            frame_err_q  <= 1'b0;
        end else begin
            clk_meta_q   <= ps2_clk;
            clk_sync_q   <= clk_meta_q;
            data_meta_q  <= ps2_data;
            data_sync_q  <= data_meta_q;
            hist_q       <= hist_d;
            filt_q       <= filt_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            tmo_q        <= tmo_d;
            byte_valid_q <= byte_valid_d;
            scan_byte_q  <= scan_byte_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign byte_valid = byte_valid_q;
    assign scan_byte  = scan_byte_q;
    assign frame_err  = frame_err_q;

endmodule

// File: rtl/ps2_keycode_source.sv
// ps2_keycode_source: PS/2 keyboard to HID keycode bridge for player motion.
//   Clk, Reset          system clock, async active-high reset
//   ps2_clk, ps2_data   raw PS/2 lines
//   keycode             HID code of the active key, 00 when none held
//   held                held mask: bit0 A, bit1 D, bit2 S, bit3 W, bit4 Space
//   byte_valid          one-cycle pulse per correctly framed byte
//   scan_byte           last correctly framed byte
//   frame_err           one-cycle pulse on any framing error
module ps2_keycode_source
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keycode,
    output logic [4:0] held,
    output logic       byte_valid,
    output logic [7:0] scan_byte,
    output logic       frame_err
);

    logic       ext_q, ext_d, brk_q, brk_d;
    logic [4:0] held_q, held_d;
    key_idx_e   last_q, last_d, idx, low_idx;
    logic [7:0] keycode_q, keycode_d;

    ps2_rx_frame #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .Clk       (Clk),
        .Reset     (Reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .byte_valid(byte_valid),
        .scan_byte (scan_byte),
        .frame_err (frame_err)
    );

    always_comb begin
        ext_d  = ext_q;
        brk_d  = brk_q;
        held_d = held_q;
        last_d = last_q;
        idx    = scan_to_idx(scan_byte);

        if (frame_err) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (byte_valid) begin
            if (scan_byte == PS2_EXT) begin
                ext_d = 1'b1;
            end else if (scan_byte == PS2_BRK) begin
                brk_d = 1'b1;
            end else begin
                // Extended codes alias tracked codes (E0 1C etc.) and are not ours
                if (!ext_q && idx != KeyNone) begin
                    if (brk_q) begin
                        held_d[idx] = 1'b0;
                    end else begin
                        held_d[idx] = 1'b1;
                        last_d      = idx;
                    end
                end
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end

        low_idx = KeyNone;
        for (int i = 4; i >= 0; i--) begin
            if (held_d[i]) low_idx = key_idx_e'(3'(i));
        end

        // Computed from next-state so keycode and held move on the same edge
        if (last_d != KeyNone && held_d[last_d]) keycode_d = idx_to_hid(last_d);
        else                                     keycode_d = idx_to_hid(low_idx);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
            held_q    <= 5'b0;
            last_q    <= KeyNone;
            keycode_q <= HID_NONE;
        end else begin
            ext_q     <= ext_d;
            brk_q     <= brk_d;
            held_q    <= held_d;
            last_q    <= last_d;
            keycode_q <= keycode_d;
        end
    end

    assign keycode = keycode_q;
    assign held    = held_q;

endmodule
